// File: rtl/register_file.sv
// 32 x DATA_WIDTH register file, two combinational read ports, one write port.
// Define REGFILE_WRITE_BYPASS_EN to forward same-cycle write data to reads.
module register_file #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  Reg_Write_i,
  input  logic [4:0]            Write_Register_i,
  input  logic [DATA_WIDTH-1:0] Write_Data_i,
  input  logic [4:0]            Read_Register_1_i,
  input  logic [4:0]            Read_Register_2_i,
  output logic [DATA_WIDTH-1:0] Read_Data_1_o,
  output logic [DATA_WIDTH-1:0] Read_Data_2_o
);

  logic [DATA_WIDTH-1:0] regs [32];
  logic                  wr_en;
  logic                  fwd_1;
  logic                  fwd_2;

  assign wr_en = Reg_Write_i && (Write_Register_i != 5'd0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 32; i++) begin
        regs[i] <= '0;
      end
    end else if (wr_en) begin
      regs[Write_Register_i] <= Write_Data_i;
    end
  end

`ifdef REGFILE_WRITE_BYPASS_EN
  assign fwd_1 = wr_en && reset &&
                 (Read_Register_1_i == Write_Register_i);
  assign fwd_2 = wr_en && reset &&
                 (Read_Register_2_i == Write_Register_i);
`else
  assign fwd_1 = 1'b0;
  assign fwd_2 = 1'b0;
`endif

  // r0 is forced to zero on the read side regardless of storage
  always_comb begin
    Read_Data_1_o = regs[Read_Register_1_i];
    if (Read_Register_1_i == 5'd0) begin
      Read_Data_1_o = '0;
    end else if (fwd_1) begin
      Read_Data_1_o = Write_Data_i;
    end
  end

  always_comb begin
    Read_Data_2_o = regs[Read_Register_2_i];
    if (Read_Register_2_i == 5'd0) begin
      Read_Data_2_o = '0;
    end else if (fwd_2) begin
      Read_Data_2_o = Write_Data_i;
    end
  end

endmodule

// File: tb/tb_register_file.sv
// Randomized self-checking bench for register_file against an array model.
// Bypass expectations follow REGFILE_WRITE_BYPASS_EN when it is defined.
module tb_register_file;

  logic        clk;
  logic        reset;
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic [4:0]  ra1;
  logic [4:0]  ra2;
  logic [31:0] rd1;
  logic [31:0] rd2;

  logic [31:0] model [32];
  int          n_cmp;
  int          n_err;

  register_file #(.DATA_WIDTH(32)) dut (
    .clk               (clk),
    .reset             (reset),
    .Reg_Write_i       (we),
    .Write_Register_i  (waddr),
    .Write_Data_i      (wdata),
    .Read_Register_1_i (ra1),
    .Read_Register_2_i (ra2),
    .Read_Data_1_o     (rd1),
    .Read_Data_2_o     (rd2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] expect_rd(input logic [4:0] a);
    if (a == 5'd0 || !reset) return 32'd0;
`ifdef REGFILE_WRITE_BYPASS_EN
    if (we && a == waddr) return wdata;
`endif
    return model[a];
  endfunction

  task automatic clear_model();
    for (int i = 0; i < 32; i++) model[i] = 32'd0;
  endtask

  task automatic check_ports(input string tag);
    #1;
    check({tag, "_p1"}, rd1, expect_rd(ra1));
    check({tag, "_p2"}, rd2, expect_rd(ra2));
  endtask

  task automatic do_write(input logic [4:0] a,
                          input logic [31:0] d);
    @(negedge clk);
    we = 1'b1;
    waddr = a;
    wdata = d;
    @(posedge clk);
    if (reset && a != 5'd0) model[a] = d;
    #1;
    we = 1'b0;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    clear_model();
    reset = 1'b0;
    we = 1'b1;
    waddr = 5'd3;
    wdata = 32'd55;
    ra1 = 5'd3;
    ra2 = 5'd3;

    // write attempt while reset is held must be dropped
    repeat (2) @(posedge clk);
    #1;
    check("rst_wr_blk_p1", rd1, 32'd0);
    check("rst_wr_blk_p2", rd2, 32'd0);

    @(negedge clk);
    we = 1'b0;
    reset = 1'b1;
    for (int i = 0; i < 32; i++) begin
      ra1 = 5'(i);
      ra2 = 5'(31 - i);
      #1;
      check("rst_clear_p1", rd1, 32'd0);
      check("rst_clear_p2", rd2, 32'd0);
    end

    do_write(5'd1, 32'd88);
    do_write(5'd2, 32'd77);
    do_write(5'd3, 32'd20);
    ra1 = 5'd1; ra2 = 5'd3; #1;
    check("seq_r1_p1", rd1, 32'd88);
    check("seq_r3_p2", rd2, 32'd20);
    ra1 = 5'd2; ra2 = 5'd2; #1;
    check("seq_r2_p1", rd1, 32'd77);
    check("seq_r2_p2", rd2, 32'd77);
    ra1 = 5'd3; ra2 = 5'd1; #1;
    check("seq_r3_p1", rd1, 32'd20);
    check("seq_r1_p2", rd2, 32'd88);

    do_write(5'd0, 32'd100);
    ra1 = 5'd0; ra2 = 5'd0; #1;
    check("r0_p1", rd1, 32'd0);
    check("r0_p2", rd2, 32'd0);

    do_write(5'd5, 32'd78);
    @(negedge clk);
    we = 1'b0;
    waddr = 5'd5;
    wdata = 32'd61;
    repeat (3) @(posedge clk);
    ra1 = 5'd5; ra2 = 5'd5; #1;
    check("we_gate_p1", rd1, 32'd78);
    check("we_gate_p2", rd2, 32'd78);

    for (int i = 1; i <= 10; i++) do_write(5'(i), $urandom);
    ra1 = 5'd8; ra2 = 5'd1;
    check_ports("filled");
    @(negedge clk);
    #1;
    reset = 1'b0;
    clear_model();
    #1;
    check("async_rst_p1", rd1, 32'd0);
    check("async_rst_p2", rd2, 32'd0);
    #1;
    reset = 1'b1;
    #1;
    check("post_rst_p1", rd1, 32'd0);
    check("post_rst_p2", rd2, 32'd0);
    do_write(5'd8, 32'd27);
    ra1 = 5'd8; #1;
    check("post_rst_wr", rd1, 32'd27);

    @(negedge clk);
    we = 1'b1;
    waddr = 5'd4;
    wdata = 32'd66;
    ra1 = 5'd4;
    ra2 = 5'd0;
    #1;
`ifdef REGFILE_WRITE_BYPASS_EN
    check("bypass_pre", rd1, 32'd66);
`else
    check("nobypass_pre", rd1, 32'd0);
`endif
    check("bypass_r0", rd2, 32'd0);
    @(posedge clk);
    model[4] = 32'd66;
    #1;
    check("bypass_post", rd1, 32'd66);
    we = 1'b0;

    repeat (300) begin
      @(negedge clk);
      if ($urandom_range(0, 49) == 0) begin
        #1;
        reset = 1'b0;
        clear_model();
        check_ports("rnd_rst");
        reset = 1'b1;
      end
      we = 1'($urandom_range(0, 1));
      waddr = 5'($urandom);
      wdata = $urandom;
      ra1 = ($urandom_range(0, 1) == 1) ? waddr : 5'($urandom);
      ra2 = 5'($urandom);
      check_ports("rnd_pre");
      @(posedge clk);
      if (we && waddr != 5'd0) model[waddr] = wdata;
      check_ports("rnd_post");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/register_file.md
REGISTER_FILE -- requirements
Module: register_file

Interface
REQ-001 Parameter: DATA_WIDTH, default 32, register and data-port width; all other widths are fixed.
REQ-002 Port: clk  input  1  single clock; all writes on rising edge.
REQ-003 Port: reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-004 Port: Reg_Write_i  input  1  write enable, active-high.
REQ-005 Port: Write_Register_i  input  5  write address, 0..31.
REQ-006 Port: Write_Data_i  input  DATA_WIDTH  write data.
REQ-007 Port: Read_Register_1_i  input  5  read address, port 1.
REQ-008 Port: Read_Register_2_i  input  5  read address, port 2.
REQ-009 Port: Read_Data_1_o  output  DATA_WIDTH  read data, port 1.
REQ-010 Port: Read_Data_2_o  output  DATA_WIDTH  read data, port 2.

Function
REQ-011 The block SHALL hold 32 registers of DATA_WIDTH bits, indexed 0..31: 2 read ports and 1 write port.
REQ-012 On a rising clk edge with reset=1 and Reg_Write_i=1, register[Write_Register_i] SHALL load Write_Data_i.
REQ-013 With Reg_Write_i=0, no register SHALL change.
REQ-014 Register 0 SHALL read as all-zeros at all times, and writes to address 0 SHALL be ignored.
REQ-015 Read ports SHALL be combinational, with zero-cycle latency: Read_Data_N_o = register[Read_Register_N_i], updating within the same cycle an address changes.
REQ-016 Both read ports SHALL be independent and SHALL allow the same address concurrently, with identical output.
REQ-017 A written value SHALL be visible on a read port addressing it immediately after the write edge; without the bypass (REQ-023), the old value is shown before the edge.
REQ-018 Only one register SHALL be written per edge, and no register other than the addressed one SHALL change.
REQ-019 Outputs SHALL never be X/Z after reset has been asserted once.

Reset
REQ-020 reset=0 SHALL clear registers 1..31 to 0 immediately, without waiting for clk, and both read outputs SHALL show 0 for any address.
REQ-021 While reset=0, writes SHALL be blocked, including an edge with Reg_Write_i=1.
REQ-022 Reset asserted mid-operation SHALL discard all stored contents. After reset deasserts, the first rising edge with Reg_Write_i=1 SHALL write normally.

Configuration
REQ-023 Macro REGFILE_WRITE_BYPASS_EN: when defined, a read port SHALL output Write_Data_i combinationally if all of these hold: Reg_Write_i=1, reset=1, its read address equals Write_Register_i, and the address is nonzero. This is write-to-read forwarding within the same cycle.
REQ-024 When REGFILE_WRITE_BYPASS_EN is undefined, reads SHALL return the stored value only, with no forwarding.

Verification
REQ-025 Reset: hold reset=0, then release. Read addresses 0..31 on both ports -> all outputs 0.
REQ-026 Write 88 to r1, 77 to r2, 20 to r3 on consecutive edges with Reg_Write_i=1. Then read r1/r2/r3 on port 1 and r3/r2/r1 on port 2 -> port 1 gives 88/77/20 and port 2 gives 20/77/88.
REQ-027 R0 protection: write 100 to address 0 -> both ports reading address 0 return 0.
REQ-028 Write-enable gating: set r5=78, then drive Reg_Write_i=0 with Write_Register_i=5 and Write_Data_i=61 across edges -> r5 remains 78.
REQ-029 Async reset mid-run: after filling r1..r10, pulse reset=0 between clock edges -> outputs go to 0 before the next edge, and a subsequent write of 27 to r8 reads back 27.
REQ-030 Bypass: same cycle, write r4=66 while port 1 reads r4 (old value 0) -> with REGFILE_WRITE_BYPASS_EN, port 1 shows 66 before the edge; without it, port 1 shows 0 until the edge, then 66.
